// File: rtl/bp_pkg.sv
// Shared types and default constants for the Bp bus arbiter.
package bp_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_XFER  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } bp_state_e;

  localparam int unsigned BP_N_DEFAULT       = 4;
  localparam int unsigned BP_TIMEOUT_DEFAULT = 200;
  localparam int unsigned BP_TO_W_DEFAULT    = 8;

endpackage

// File: rtl/bp_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request bit searching
// upward from (last+1) mod N, returned as one-hot and as an index.
module rr_pick
  import bp_pkg::*;
#(
  parameter int unsigned N  = BP_N_DEFAULT,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] j;
  logic          found;

  // Rotating priority scan starting just after the last winner.
  always_comb begin
    pick  = '0;
    idx   = '0;
    j     = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      j = IW'((32'(last) + i) % N);
      if (!found && req[j]) begin
        found   = 1'b1;
        pick[j] = 1'b1;
        idx     = j;
      end
    end
  end

endmodule

// File: rtl/bp_bus_arbiter.sv
// Round-robin arbiter and transaction sequencer for the shared Bp bus.
// Optional XFER wait timeout is compiled in with BP_ARB_TIMEOUT_EN.
module bp_bus_arbiter
  import bp_pkg::*;
#(
  parameter int unsigned N       = BP_N_DEFAULT,
  parameter int unsigned TIMEOUT = BP_TIMEOUT_DEFAULT,
  parameter int unsigned TO_W    = BP_TO_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] wr,
  output logic [N-1:0] gnt,
  output logic [N-1:0] done,
  output logic [N-1:0] err,
  output logic         bus_valid,
  output logic         bus_wr,
  output logic         bus_clear,
  input  logic         bus_wait,
  input  logic         bus_error
);

  localparam int unsigned IW = $clog2(N);

  bp_state_e     state_q, state_d;
  logic [IW-1:0] sel_q, sel_d;
  logic [N-1:0]  sel_oh_q, sel_oh_d;
  logic [IW-1:0] last_q, last_d;
  logic          wr_cap_q, wr_cap_d;

  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  done_q, done_d;
  logic [N-1:0]  err_q, err_d;
  logic          valid_q, valid_d;
  logic          bwr_q, bwr_d;
  logic          clr_q, clr_d;
  logic          busy_d;

  logic [N-1:0]  pick_oh;
  logic [IW-1:0] pick_idx;
  logic          timeout;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_rr_pick (
    .req  (req),
    .last (last_q),
    .pick (pick_oh),
    .idx  (pick_idx)
  );

`ifdef BP_ARB_TIMEOUT_EN
  logic [TO_W-1:0] cnt_q, cnt_d;

  assign timeout = (cnt_q == TO_W'(TIMEOUT - 1));

  // Wait counter: cleared in GRANT, advances on each stalled XFER cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_GRANT) begin
      cnt_d = '0;
    end else if (state_q == S_XFER && !bus_error && bus_wait && !timeout) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // Next state, captured selection, and output terms. Outputs are derived
  // from the next state so every output is a flop with no input-to-output path.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    sel_oh_d = sel_oh_q;
    wr_cap_d = wr_cap_q;
    last_d   = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (|pick_oh) begin
          state_d  = S_GRANT;
          sel_d    = pick_idx;
          sel_oh_d = pick_oh;
          wr_cap_d = |(wr & pick_oh);
        end
      end
      S_GRANT: state_d = S_XFER;
      S_XFER: begin
        if (bus_error)     state_d = S_ERR;
        else if (!bus_wait) state_d = S_DONE;
        else if (timeout)  state_d = S_ERR;
      end
      S_DONE, S_ERR: begin
        last_d  = sel_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d == S_GRANT) || (state_d == S_XFER);
    gnt_d   = busy_d ? sel_oh_d : '0;
    valid_d = busy_d;
    bwr_d   = busy_d & wr_cap_d;
    done_d  = (state_d == S_DONE) ? sel_oh_d : '0;
    err_d   = (state_d == S_ERR)  ? sel_oh_d : '0;
    clr_d   = (state_d == S_ERR);
  end

  // State, selection and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      sel_oh_q <= '0;
      last_q   <= IW'(N - 1);
      wr_cap_q <= 1'b0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      valid_q  <= 1'b0;
      bwr_q    <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      sel_oh_q <= sel_oh_d;
      last_q   <= last_d;
      wr_cap_q <= wr_cap_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      bwr_q    <= bwr_d;
      clr_q    <= clr_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign bus_valid = valid_q;
  assign bus_wr    = bwr_q;
  assign bus_clear = clr_q;

endmodule
